uart_rx_fifo: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo_core.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-buffer register window.
package uart_pkg;

  // Word offsets inside the register window
  localparam logic [3:0] UART_RXF_DATA = 4'h0;
  localparam logic [3:0] UART_RXF_STAT = 4'h1;
  localparam logic [3:0] UART_RXF_CTRL = 4'h2;

  // STATUS register bit positions
  localparam int EMPTY = 0;
  localparam int FULL  = 1;
  localparam int OVF   = 2;

  // CTRL register bit positions
  localparam int CTRL_FLUSH_BIT = 31;
  localparam int CTRL_IRQEN_BIT = 8;

endpackage

// File: rtl/sync_fifo_core.sv
// Byte FIFO core: storage array, wrapping pointers, occupancy counter and
// push/pop/flush arbitration. Head byte is presented combinationally.
module sync_fifo_core #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  push_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign level = level_reg;
  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_FULL);

  // Flush overrides everything; a pop frees the slot a full-FIFO push needs
  assign pop_ok    = pop & ~empty & ~flush;
  assign push_ok   = push & ~flush & (~full | pop_ok);
  assign push_drop = push & ~flush & full & ~pop_ok;

  assign head = empty ? 8'h00 : mem[rd_ptr_reg];

  // Storage array: contents are not reset
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push_ok && !pop_ok)      level_reg <= level_reg + LVL_ONE;
      else if (!push_ok && pop_ok) level_reg <= level_reg - LVL_ONE;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FIFO of received bytes behind a DATA/STATUS/CTRL
// register window, with a sticky overflow flag and level/overflow IRQ.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rstn,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        m_sel,
  input  logic [3:0]  m_addr,
  input  logic [31:0] m_data_i,
  output logic [31:0] m_data_o,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic        irq_o
);

  logic [7:0]          head;
  logic [DEPTH_LOG2:0] level;
  logic                empty;
  logic                full;
  logic                push_drop;
  logic                wr_data;
  logic                wr_stat;
  logic                wr_ctrl;
  logic                flush;
  logic                ovf_reg;
  logic                irq_en_reg;
  logic [7:0]          thr_reg;
  logic                irq_reg;
  logic [7:0]          level_byte;
  logic                lvl_hit;

  // Reads are side-effect free, so m_rd only qualifies intent on the bus
  logic unused_bus;
  assign unused_bus = &{1'b0, m_rd, m_data_i[30:9]};

  assign wr_data = m_sel & m_wr & (m_addr == UART_RXF_DATA);
  assign wr_stat = m_sel & m_wr & (m_addr == UART_RXF_STAT);
  assign wr_ctrl = m_sel & m_wr & (m_addr == UART_RXF_CTRL);
  assign flush   = wr_ctrl & m_data_i[CTRL_FLUSH_BIT];

  sync_fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_core (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .push      (rx_valid_i),
    .pop       (wr_data),
    .flush     (flush),
    .din       (rx_data_i),
    .head      (head),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .push_drop (push_drop)
  );

  // Level field is 8 bits wide; at DEPTH_LOG2=8 a full FIFO wraps to 0 there
  // but the FULL bit still reports it
  assign level_byte = 8'(level);
  assign lvl_hit    = (thr_reg != 8'h00) && (int'(level) >= int'(thr_reg));

  // Sticky overflow: a set in the same cycle as a clear wins
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)                       ovf_reg <= 1'b0;
    else if (push_drop)              ovf_reg <= 1'b1;
    else if (wr_stat && m_data_i[OVF]) ovf_reg <= 1'b0;
  end

  // CTRL register: threshold and IRQ enable, loaded on every CTRL write
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      thr_reg    <= 8'h00;
      irq_en_reg <= 1'b0;
    end else if (wr_ctrl) begin
      thr_reg    <= m_data_i[7:0];
      irq_en_reg <= m_data_i[CTRL_IRQEN_BIT];
    end
  end

  // Registered interrupt from the current-cycle level and overflow state
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) irq_reg <= 1'b0;
    else       irq_reg <= irq_en_reg & (lvl_hit | ovf_reg);
  end

  assign irq_o = irq_reg;

  // Combinational read decode; zero when the window is not selected
  always_comb begin
    m_data_o = 32'h0;
    if (m_sel) begin
      case (m_addr)
        UART_RXF_DATA: m_data_o = {23'b0, ~empty, head};
        UART_RXF_STAT: m_data_o = {16'b0, level_byte, 5'b0, ovf_reg, full, empty};
        UART_RXF_CTRL: m_data_o = {23'b0, irq_en_reg, thr_reg};
        default:       m_data_o = 32'h0;
      endcase
    end
  end

endmodule
